// File: rtl/mgia_vfetch.sv
// Video fetch engine: reads one frame of VRAM words into a small prefetch FIFO.
// Optional sticky underrun flag enabled by defining MGIA_VFETCH_UNDERRUN_EN.
module mgia_vfetch #(
  parameter int unsigned FRAME_WORDS = 8000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        FRAME_I,
  output logic [12:0] VF_ADR_O,
  output logic        VF_CYC_O,
  output logic        VF_STB_O,
  input  logic        VF_ACK_I,
  input  logic [15:0] VF_DAT_I,
  output logic [15:0] DAT_O,
  output logic        VALID_O,
  input  logic        POP_I,
  output logic        UNDERRUN_O
);

  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned WCW = 14;
  localparam int unsigned AW  = 13;

  typedef enum logic [1:0] {IDLE, FETCH, ABORT, DONE} state_t;

  state_t          state_q, state_d;
  logic            cyc_d, stb_d;
  logic [AW-1:0]   adr_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [15:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, cnt_keep, cnt_push;
  logic            push, pop_ok, flush;

  assign VALID_O = (count != '0);
  assign DAT_O   = mem[rd_ptr];

  // Next-state, bus handshake and FIFO control
  always_comb begin
    state_d  = state_q;
    cyc_d    = VF_CYC_O;
    stb_d    = VF_STB_O;
    adr_d    = VF_ADR_O;
    wcnt_d   = wcnt_q;
    push     = 1'b0;
    flush    = 1'b0;
    pop_ok   = POP_I && (count != '0);
    cnt_keep = count - CW'(pop_ok);
    cnt_push = cnt_keep + CW'(1);
    if (FRAME_I) begin
      // Frame start wins over any ack in the same cycle
      state_d = ABORT;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      adr_d   = '0;
      wcnt_d  = '0;
      flush   = 1'b1;
    end else begin
      case (state_q)
        ABORT: begin
          state_d = FETCH;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
        end
        FETCH: begin
          if (VF_STB_O && VF_ACK_I) begin
            push = 1'b1;
            if (wcnt_q == WCW'(FRAME_WORDS - 1)) begin
              state_d = DONE;
              cyc_d   = 1'b0;
              stb_d   = 1'b0;
            end else begin
              adr_d  = VF_ADR_O + AW'(1);
              wcnt_d = wcnt_q + WCW'(1);
              stb_d  = (cnt_push < CW'(FIFO_DEPTH));
            end
          end else if (!VF_STB_O) begin
            stb_d = (cnt_keep < CW'(FIFO_DEPTH));
          end
        end
        default: ;
      endcase
    end
  end

  // State, bus outputs and FIFO storage
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= IDLE;
      VF_CYC_O <= 1'b0;
      VF_STB_O <= 1'b0;
      VF_ADR_O <= '0;
      wcnt_q   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      state_q  <= state_d;
      VF_CYC_O <= cyc_d;
      VF_STB_O <= stb_d;
      VF_ADR_O <= adr_d;
      wcnt_q   <= wcnt_d;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= VF_DAT_I;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop_ok);
      end
    end
  end

`ifdef MGIA_VFETCH_UNDERRUN_EN
  logic underrun_q;

  // Sticky: consumer popped an empty FIFO while the frame was fetching
  always_ff @(posedge CLK_I) begin
    if (RST_I || flush) underrun_q <= 1'b0;
    else if (POP_I && (count == '0) && (state_q == FETCH)) underrun_q <= 1'b1;
  end

  assign UNDERRUN_O = underrun_q;
`else
  assign UNDERRUN_O = 1'b0;
`endif

endmodule

// File: doc/mgia_vfetch.md
MGIA_VFETCH -- requirements
Module: mgia_vfetch

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 8000: words fetched per frame, 1..8192.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: prefetch FIFO entries, power of 2, 2..16.
REQ-003 SHALL have port CLK_I  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_I  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port FRAME_I  input  1  one-cycle frame-start pulse.
REQ-006 SHALL have port VF_ADR_O  output  13  VRAM word address.
REQ-007 SHALL have port VF_CYC_O  output  1  bus cycle active.
REQ-008 SHALL have port VF_STB_O  output  1  bus strobe.
REQ-009 SHALL have port VF_ACK_I  input  1  VRAM acknowledge; VF_DAT_I valid when high.
REQ-010 SHALL have port VF_DAT_I  input  16  VRAM read data.
REQ-011 SHALL have port DAT_O  output  16  FIFO head word.
REQ-012 SHALL have port VALID_O  output  1  FIFO not empty.
REQ-013 SHALL have port POP_I  input  1  consumer removes head word.
REQ-014 SHALL have port UNDERRUN_O  output  1  sticky underrun flag (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, ABORT, DONE; one read outstanding at most.
REQ-016 IDLE: CYC/STB low; FRAME_I -> ABORT.
REQ-017 FETCH: VF_CYC_O high; VF_STB_O high while FIFO not full or a request is pending; once STB rises it SHALL stay high with VF_ADR_O stable until VF_ACK_I is sampled high.
REQ-018 On edge with VF_ACK_I and STB high: push VF_DAT_I into FIFO, VF_ADR_O increments by 1; STB may remain high for the next address (back-to-back, one word per two cycles against the VRAM's alternating ack).
REQ-019 After FRAME_WORDS words acknowledged -> DONE: CYC/STB low, VF_ADR_O holds FRAME_WORDS-1 wrapped to 13 bits; stays until FRAME_I.
REQ-020 FRAME_I in any state other than reset -> ABORT next edge; any VF_ACK_I sampled in that same cycle SHALL be discarded.
REQ-021 ABORT: exactly one cycle, CYC/STB low (guarantees responder ack state clears), FIFO flushed, VF_ADR_O = 0, word counter = 0; then -> FETCH.
REQ-022 FIFO: DAT_O shows head combinationally from storage; VALID_O = count != 0.
REQ-023 POP_I with VALID_O removes head; POP_I with VALID_O low SHALL be ignored (no state change to FIFO).
REQ-024 Simultaneous push and pop: count unchanged, head advances, new word appended; legal when full only if pop present (push never occurs while full by REQ-017).
REQ-025 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-026 VF_ACK_I while STB low SHALL be ignored.

Reset
REQ-027 RST_I high at a rising edge SHALL force: state IDLE, VF_CYC_O 0, VF_STB_O 0, VF_ADR_O 0, FIFO empty, VALID_O 0, DAT_O 0 after reset, UNDERRUN_O 0, word counter 0.
REQ-028 RST_I SHALL take priority over FRAME_I, VF_ACK_I and POP_I; reset mid-transaction drops the cycle without waiting for ack.

Configuration
REQ-029 Macro MGIA_VFETCH_UNDERRUN_EN defined: UNDERRUN_O set on edge where POP_I high and VALID_O low while state is FETCH; cleared only by RST_I or ABORT.
REQ-030 Macro MGIA_VFETCH_UNDERRUN_EN undefined: UNDERRUN_O tied 0, no flag logic; all other behaviour identical.

Verification
REQ-031 Reset then FRAME_I, VRAM model with 1-cycle alternating ack, no pops -> addresses 0,1,2,3 read, FIFO full (4), STB low, VALID_O 1, DAT_O = word 0.
REQ-032 FRAME_WORDS=8, pop every cycle VALID_O high -> exactly 8 words delivered in address order 0..7, then DONE, CYC low, no further requests.
REQ-033 FRAME_I asserted on the ACK cycle of address 5 -> that word discarded, one cycle CYC low, fetch restarts at address 0, FIFO empty after ABORT.
REQ-034 FIFO full, POP_I and ACK same edge -> count stays 4, head advances to next word, new word at tail.
REQ-035 With MGIA_VFETCH_UNDERRUN_EN, POP_I on empty FIFO in FETCH -> UNDERRUN_O 1 next cycle, stays 1 until FRAME_I; without macro UNDERRUN_O stays 0.
REQ-036 RST_I asserted while STB high awaiting ack -> next cycle CYC/STB 0, VF_ADR_O 0, VALID_O 0.
